// File: rtl/tx_lane_framer.sv
// tx_lane_framer: per-lane Gen3 128b/130b transmit framer driving an 8-bit PIPE lane.
// Define TX_DATA_VALID_STALL_EN to insert the one-cycle TX_Data_Valid stall after every 4th block.
module tx_lane_framer #(
  parameter int          CNT_WIDTH = 4,
  parameter logic [23:0] SEED      = 24'hFFFFFF
) (
  input  logic                 local_clk,
  input  logic                 local_rst,
  input  logic                 enable,
  input  logic                 Soft_RST_blocks,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [0:7]           in_data,
  input  logic                 in_block_type,
  output logic [0:7]           TX_Data,
  output logic                 TX_Data_Valid,
  output logic                 TX_Start_Block,
  output logic [0:1]           TX_SYNC_Header,
  output logic [CNT_WIDTH-1:0] symbol_count,
  output logic                 underrun_err,
  output logic [3:0]           dbg_status
);
  // Handshake: a symbol transfers in a cycle where in_valid && in_ready. in_ready depends only
  // on state, enable and sym_cnt (never on in_valid); upstream must hold in_data until accepted.

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_STALL  = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] SYM_LAST = CNT_WIDTH'(15);
  localparam logic [22:0]          SEED_23  = SEED[22:0];

  state_t               state, state_n;
  logic [CNT_WIDTH-1:0] sym_cnt;
  logic [1:0]           blk_cnt;
  logic [22:0]          lfsr, lfsr_adv;
  logic [0:7]           ks;
  logic                 blk_type_q, eieos_q;
  logic                 transfer, sym_first, sym_last, stall_trig;
  logic                 clear_cnt, clear_out, cur_type, cur_eieos, underrun;

  assign sym_first = (sym_cnt == '0);
  assign sym_last  = (sym_cnt == SYM_LAST);
  assign transfer  = in_valid && in_ready;
  assign clear_cnt = Soft_RST_blocks || (state == S_IDLE && !enable);
  assign clear_out = Soft_RST_blocks || (state == S_IDLE);

  // Block type and EIEOS flag come straight from the inputs on symbol 0, then from the latches.
  assign cur_type  = sym_first ? in_block_type : blk_type_q;
  assign cur_eieos = sym_first ? (!in_block_type && in_data == 8'h00) : eieos_q;

`ifdef TX_DATA_VALID_STALL_EN
  assign stall_trig = transfer && sym_last && (blk_cnt == 2'd3);
`else
  assign stall_trig = 1'b0;
`endif

  // State register
  always_ff @(posedge local_clk or posedge local_rst) begin
    if (local_rst) state <= S_IDLE;
    else           state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    if (Soft_RST_blocks) begin
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (enable) state_n = S_ACTIVE;
        S_ACTIVE: begin
          if (!enable && sym_first) state_n = S_IDLE;
          else if (stall_trig)      state_n = S_STALL;
        end
        S_STALL:  state_n = S_ACTIVE;
        default:  state_n = S_IDLE;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    in_ready   = (state == S_ACTIVE) && !(!enable && sym_first);
    underrun   = (state == S_ACTIVE) && !in_valid && !sym_first;
    dbg_status = {blk_cnt, state};
  end

  // Eight serial steps of the Fibonacci LFSR; first keystream bit scrambles in_data[0].
  always_comb begin
    lfsr_adv = lfsr;
    ks       = '0;
    for (int i = 0; i < 8; i++) begin
      ks[i]    = lfsr_adv[22];
      lfsr_adv = {lfsr_adv[21:0],
                  lfsr_adv[22] ^ lfsr_adv[20] ^ lfsr_adv[15] ^ lfsr_adv[7] ^ lfsr_adv[4] ^ lfsr_adv[1]};
    end
  end

  // Counters, block-type latch and scrambler state
  always_ff @(posedge local_clk or posedge local_rst) begin
    if (local_rst) begin
      sym_cnt    <= '0;
      blk_cnt    <= '0;
      lfsr       <= SEED_23;
      blk_type_q <= 1'b0;
      eieos_q    <= 1'b0;
    end else if (clear_cnt) begin
      sym_cnt    <= '0;
      blk_cnt    <= '0;
      lfsr       <= SEED_23;
      blk_type_q <= 1'b0;
      eieos_q    <= 1'b0;
    end else if (transfer) begin
      sym_cnt <= sym_last ? '0 : sym_cnt + CNT_WIDTH'(1);
      if (sym_last) blk_cnt <= blk_cnt + 2'd1;
      if (sym_first) begin
        blk_type_q <= in_block_type;
        eieos_q    <= !in_block_type && (in_data == 8'h00);
      end
      if (sym_last && cur_eieos) lfsr <= SEED_23;
      else if (cur_type)         lfsr <= lfsr_adv;
    end
  end

  // Registered PIPE outputs: a symbol accepted in cycle N is presented in cycle N+1.
  always_ff @(posedge local_clk or posedge local_rst) begin
    if (local_rst) begin
      TX_Data        <= '0;
      TX_Data_Valid  <= 1'b0;
      TX_Start_Block <= 1'b0;
      TX_SYNC_Header <= 2'b00;
      symbol_count   <= '0;
      underrun_err   <= 1'b0;
    end else if (clear_out) begin
      TX_Data        <= '0;
      TX_Data_Valid  <= 1'b0;
      TX_Start_Block <= 1'b0;
      TX_SYNC_Header <= 2'b00;
      symbol_count   <= '0;
      underrun_err   <= 1'b0;
    end else begin
      underrun_err   <= underrun;
      TX_Data_Valid  <= transfer;
      TX_Start_Block <= transfer && sym_first;
      if (transfer) begin
        TX_Data        <= cur_type ? (in_data ^ ks) : in_data;
        symbol_count   <= sym_cnt;
        TX_SYNC_Header <= sym_first ? (in_block_type ? 2'b10 : 2'b01) : 2'b00;
      end else begin
        TX_SYNC_Header <= 2'b00;
      end
    end
  end

endmodule
